// File: rtl/sing_pkg.sv
// Shared types and constants for the point-capture transmitter.
// Holds the sequencer state encoding, the table slot numbering and the phase-counter width helper.
package sing_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    GAP     = 3'd3,
    FSETUP  = 3'd4,
    FSTROBE = 3'd5,
    FGAP    = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [1:0] IDX_P1 = 2'd0;
  localparam logic [1:0] IDX_P2 = 2'd1;
  localparam logic [1:0] IDX_P3 = 2'd2;
  localparam logic [1:0] IDX_PT = 2'd3;

  // Counter must hold the longer of the two phase lengths without wrapping.
  function automatic int phase_cw(input int hold_cyc, input int gap_cyc);
    return $clog2(((hold_cyc > gap_cyc) ? hold_cyc : gap_cyc) + 1);
  endfunction

endpackage

// File: rtl/sing_strobe_gen.sv
// Phase counter for one strobe frame: a HOLD_CYC high phase followed by a GAP_CYC low phase.
// The counter reloads on each phase entry and parks at zero rather than wrapping.
module sing_strobe_gen import sing_pkg::*; #(
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_hold,
  input  logic load_gap,
  output logic strobe,
  output logic phase_end
);

  localparam int CW = phase_cw(HOLD_CYC, GAP_CYC);

  logic [CW-1:0] cnt_r;
  logic          strobe_r;

  // Load the phase length on entry, then count down to the last cycle of the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      strobe_r <= 1'b0;
    end else if (load_hold) begin
      cnt_r    <= CW'(HOLD_CYC);
      strobe_r <= 1'b1;
    end else if (load_gap) begin
      cnt_r    <= CW'(GAP_CYC);
      strobe_r <= 1'b0;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r    <= cnt_r - CW'(1);
    end
  end

  assign phase_end = (cnt_r == CW'(1));
  assign strobe    = strobe_r;

endmodule

// File: rtl/sing_point_tx.sv
// Transmit side of the point-capture link: sends P1, P2, P3, PT (and an optional flush
// strobe) on px/py, each framed by one selPonto strobe. All outputs are registered.
module sing_point_tx import sing_pkg::*; #(
  parameter int W        = 10,
  parameter int HOLD_CYC = 2,
  parameter int GAP_CYC  = 2,
  parameter int FLUSH    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [1:0]   wr_idx,
  input  logic [W-1:0] wr_x,
  input  logic [W-1:0] wr_y,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] px,
  output logic [W-1:0] py,
  output logic         selPonto
);

  state_t       state_r, state_nxt_s;
  logic [1:0]   idx_r;
  logic         load_hold_s, load_gap_s, strobe_s, phase_end_s;
  logic [W-1:0] tbl_x_r [4];
  logic [W-1:0] tbl_y_r [4];
  logic [W-1:0] px_r, py_r;
  logic         sel_r, busy_r, done_r;

  sing_strobe_gen #(.HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .load_hold (load_hold_s),
    .load_gap  (load_gap_s),
    .strobe    (strobe_s),
    .phase_end (phase_end_s)
  );

  // Point table; writes are accepted only while idle so a running sequence sees a frozen table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        tbl_x_r[i] <= {W{1'b0}};
        tbl_y_r[i] <= {W{1'b0}};
      end
    end else if (wr_en && (state_r == IDLE)) begin
      tbl_x_r[wr_idx] <= wr_x;
      tbl_y_r[wr_idx] <= wr_y;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Point index: restarts on an accepted start, advances after each point's gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r <= IDX_P1;
    end else if ((state_r == IDLE) && start) begin
      idx_r <= IDX_P1;
    end else if ((state_r == GAP) && phase_end_s && (idx_r != IDX_PT)) begin
      idx_r <= idx_r + 2'd1;
    end
  end

  // Next-state and phase-load decode.
  always_comb begin
    state_nxt_s = state_r;
    load_hold_s = 1'b0;
    load_gap_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = SETUP;
        else       state_nxt_s = IDLE;
      end
      SETUP, FSETUP: begin
        load_hold_s = 1'b1;
        state_nxt_s = (state_r == SETUP) ? STROBE : FSTROBE;
      end
      STROBE, FSTROBE: begin
        if (phase_end_s) begin
          load_gap_s  = 1'b1;
          state_nxt_s = (state_r == STROBE) ? GAP : FGAP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      GAP: begin
        if (!phase_end_s)           state_nxt_s = GAP;
        else if (idx_r != IDX_PT)   state_nxt_s = SETUP;
        else if (FLUSH != 0)        state_nxt_s = FSETUP;
        else                        state_nxt_s = DONE;
      end
      FGAP: begin
        if (phase_end_s) state_nxt_s = DONE;
        else             state_nxt_s = FGAP;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output registers; px/py reload only at the end of a setup cycle, so they sit still under the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_r   <= {W{1'b0}};
      py_r   <= {W{1'b0}};
      sel_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (state_r == SETUP) begin
        px_r <= tbl_x_r[idx_r];
        py_r <= tbl_y_r[idx_r];
      end else if (state_r == FSETUP) begin
        px_r <= {W{1'b0}};
        py_r <= {W{1'b0}};
      end
      sel_r  <= strobe_s;
      busy_r <= (state_r != IDLE);
      done_r <= (state_r == DONE);
    end
  end

  assign px       = px_r;
  assign py       = py_r;
  assign selPonto = sel_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_sing_point_tx.sv
// Directed bench for sing_point_tx: instance 0 uses the default parameters,
// instance 1 uses HOLD_CYC=1, FLUSH=0.
module tb_sing_point_tx;

  localparam int W = 10;

  typedef struct {
    logic         we;
    logic [1:0]   idx;
    logic [W-1:0] wx, wy;
    logic [W-1:0] ex, ey;
  } vec_t;

  logic         clk, rst;
  logic         wr_en [2];
  logic [1:0]   wr_idx [2];
  logic [W-1:0] wr_x [2], wr_y [2];
  logic         start [2], busy [2], done [2], sel [2];
  logic [W-1:0] px [2], py [2];

  int checks = 0;
  int errors = 0;

  int           n [2], hi [2], lo [2], dn [2], unstable [2];
  logic         prev_s [2];
  logic [W-1:0] hx [2], hy [2];
  logic [W-1:0] cx [2][8], cy [2][8];
  int           hw [2][8], lw [2][8];
  logic [W-1:0] ex [8], ey [8];
  vec_t         tv [5];

  sing_point_tx #(.W(W), .HOLD_CYC(2), .GAP_CYC(2), .FLUSH(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_idx(wr_idx[0]), .wr_x(wr_x[0]), .wr_y(wr_y[0]),
    .start(start[0]), .busy(busy[0]), .done(done[0]), .px(px[0]), .py(py[0]), .selPonto(sel[0])
  );

  sing_point_tx #(.W(W), .HOLD_CYC(1), .GAP_CYC(2), .FLUSH(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_idx(wr_idx[1]), .wr_x(wr_x[1]), .wr_y(wr_y[1]),
    .start(start[1]), .busy(busy[1]), .done(done[1]), .px(px[1]), .py(py[1]), .selPonto(sel[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe recorder: captured point, high width, low gap and stability per strobe.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          prev_s[d] = 1'b0;
        end else begin
          if (sel[d] && !prev_s[d]) begin
            if (n[d] < 8) begin
              cx[d][n[d]] = px[d];
              cy[d][n[d]] = py[d];
              if (n[d] > 0) lw[d][n[d]-1] = lo[d];
            end
            n[d]++;
            hi[d] = 1;
            hx[d] = px[d];
            hy[d] = py[d];
          end else if (sel[d]) begin
            hi[d]++;
            if (px[d] !== hx[d] || py[d] !== hy[d]) unstable[d]++;
          end else if (prev_s[d]) begin
            if (n[d] >= 1 && n[d] <= 8) hw[d][n[d]-1] = hi[d];
            lo[d] = 1;
          end else begin
            lo[d]++;
          end
          if (done[d] === 1'b1) dn[d]++;
          prev_s[d] = sel[d];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr(input int d);
    n[d] = 0; dn[d] = 0; unstable[d] = 0; hi[d] = 0; lo[d] = 0;
  endtask

  task automatic wr(input int d, input logic [1:0] i, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    wr_en[d] = 1'b1; wr_idx[d] = i; wr_x[d] = x; wr_y[d] = y;
    @(posedge clk); #1;
    wr_en[d] = 1'b0;
  endtask

  // Pulse start (optionally with a same-cycle write) and measure edges until done.
  task automatic run(input int d, input logic wen, input logic [1:0] i,
                     input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    @(posedge clk); #1;
    start[d] = 1'b1; wr_en[d] = wen; wr_idx[d] = i; wr_x[d] = x; wr_y[d] = y;
    @(posedge clk); #1;
    start[d] = 1'b0; wr_en[d] = 1'b0;
    lat = 0;
    while (lat < 60 && done[d] !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 32'(done[d]), 32'd1);
    chk("busy_in_done", 32'(busy[d]), 32'd1);
    @(posedge clk); #1;
    chk("busy_after", 32'(busy[d]), 32'd0);
    chk("done_one_cycle", 32'(done[d]), 32'd0);
  endtask

  task automatic chk_pts(input int d, input int cnt, input int hold);
    chk("strobe_count", 32'(n[d]), 32'(cnt));
    for (int k = 0; k < cnt && k < 8; k++) begin
      chk($sformatf("pt%0d_xy", k), 32'({cx[d][k], cy[d][k]}), 32'({ex[k], ey[k]}));
      chk($sformatf("pt%0d_high", k), 32'(hw[d][k]), 32'(hold));
      if (k > 0) chk($sformatf("pt%0d_lowgap", k), 32'(lw[d][k-1]), 32'd3);
    end
    chk("px_py_stable", 32'(unstable[d]), 32'd0);
    chk("done_pulses", 32'(dn[d]), 32'd1);
  endtask

  initial begin
    int lat;
    tv[0] = '{1'b1, 2'd0, 10'd2, 10'd2, 10'd2, 10'd2};
    tv[1] = '{1'b1, 2'd1, 10'd0, 10'd0, 10'd0, 10'd0};
    tv[2] = '{1'b1, 2'd2, 10'd4, 10'd0, 10'd4, 10'd0};
    tv[3] = '{1'b1, 2'd3, 10'd3, 10'd1, 10'd3, 10'd1};
    tv[4] = '{1'b0, 2'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 1'b0; wr_idx[d] = 2'd0; wr_x[d] = '0; wr_y[d] = '0; start[d] = 1'b0;
      prev_s[d] = 1'b0;
      clr(d);
    end
    for (int k = 0; k < 8; k++) begin ex[k] = '0; ey[k] = '0; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_px", 32'(px[0]), 32'd0);
    chk("rst_py", 32'(py[0]), 32'd0);
    chk("rst_sel", 32'(sel[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic sequence with flush
    for (int i = 0; i < 5; i++) begin
      if (tv[i].we) wr(0, tv[i].idx, tv[i].wx, tv[i].wy);
      ex[i] = tv[i].ex; ey[i] = tv[i].ey;
    end
    clr(0);
    run(0, 1'b0, 2'd0, '0, '0, lat);
    chk("latency_t1", 32'(lat), 32'd26);
    chk_pts(0, 5, 2);

    // start pulsed during the third strobe must be ignored
    clr(0);
    fork
      run(0, 1'b0, 2'd0, '0, '0, lat);
      begin
        int k;
        k = 0;
        while (n[0] < 3 && k < 100) begin @(negedge clk); k++; end
        @(posedge clk); #1; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
      end
    join
    chk("latency_t3", 32'(lat), 32'd26);
    chk_pts(0, 5, 2);
    repeat (10) @(posedge clk);
    #1;
    chk("no_restart_strobes", 32'(n[0]), 32'd5);
    chk("no_restart_busy", 32'(busy[0]), 32'd0);

    // Write while busy is dropped
    clr(0);
    fork
      run(0, 1'b0, 2'd0, '0, '0, lat);
      begin
        int k;
        k = 0;
        while (n[0] < 1 && k < 100) begin @(negedge clk); k++; end
        @(posedge clk); #1; wr_en[0] = 1'b1; wr_idx[0] = 2'd1; wr_x[0] = 10'd7; wr_y[0] = 10'd7;
        @(posedge clk); #1; wr_en[0] = 1'b0;
      end
    join
    chk_pts(0, 5, 2);

    // Last write wins; a write in the start cycle is transmitted
    wr(0, 2'd0, 10'd9, 10'd9);
    wr(0, 2'd0, 10'd2, 10'd2);
    ex[1] = 10'd7; ey[1] = 10'd7;
    clr(0);
    run(0, 1'b1, 2'd1, 10'd7, 10'd7, lat);
    chk("latency_t4", 32'(lat), 32'd26);
    chk_pts(0, 5, 2);

    // Asynchronous reset during the second strobe
    clr(0);
    @(posedge clk); #1; start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    begin
      int k;
      k = 0;
      while (n[0] < 2 && k < 100) begin @(negedge clk); k++; end
    end
    chk("reached_strobe2", 32'(n[0]), 32'd2);
    #2;
    chk("sel_before_rst", 32'(sel[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_sel", 32'(sel[0]), 32'd0);
    chk("rst_async_busy", 32'(busy[0]), 32'd0);
    chk("rst_async_px", 32'(px[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin ex[k] = '0; ey[k] = '0; end
    clr(0);
    run(0, 1'b0, 2'd0, '0, '0, lat);
    chk("latency_t5", 32'(lat), 32'd26);
    chk_pts(0, 5, 2);

    // No flush, one-cycle strobes
    for (int i = 0; i < 4; i++) begin
      wr(1, tv[i].idx, tv[i].wx, tv[i].wy);
      ex[i] = tv[i].ex; ey[i] = tv[i].ey;
    end
    clr(1);
    run(1, 1'b0, 2'd0, '0, '0, lat);
    chk("latency_t6", 32'(lat), 32'd17);
    chk_pts(1, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
